// File: rtl/div_pkg.sv
`default_nettype none
// ============================================================================
// Module      : div_pkg
// Description : Shared types and helpers for the iterative unsigned divider.
// Revision    : 1.0  initial release
// ============================================================================
package div_pkg;

    localparam int DIV_WIDTH_DEFAULT = 32;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } div_state_t;

    // Iteration counter must hold the value WIDTH itself.
    function automatic int div_cnt_width(input int width);
        return $clog2(width + 1);
    endfunction

endpackage
`default_nettype wire

// File: rtl/div_step.sv
`default_nettype none
// ============================================================================
// Module      : div_step
// Description : One combinational restoring shift-subtract division step.
// Revision    : 1.0  initial release
// ============================================================================
module div_step #(
    parameter int WIDTH = 32
) (
    input  logic [WIDTH-1:0] i_rem,
    input  logic             i_dividend_msb,
    input  logic [WIDTH-1:0] i_divisor,
    output logic [WIDTH-1:0] o_rem,
    output logic             o_q_bit
);

    logic [WIDTH:0]   w_shift;
    logic [WIDTH-1:0] w_diff;

    assign w_shift = {i_rem, i_dividend_msb};
    assign o_q_bit = (w_shift >= {1'b0, i_divisor});
    // Only taken when w_shift >= divisor, so the difference fits in WIDTH bits.
    assign w_diff  = w_shift[WIDTH-1:0] - i_divisor;
    assign o_rem   = o_q_bit ? w_diff : w_shift[WIDTH-1:0];

endmodule
`default_nettype wire

// File: rtl/divider_iterative.sv
`default_nettype none
// ============================================================================
// Module      : divider_iterative
// Description : Sequential unsigned restoring divider, one quotient bit/clock.
// Revision    : 1.0  initial release
// ============================================================================
module divider_iterative
    import div_pkg::*;
#(
    parameter int WIDTH = DIV_WIDTH_DEFAULT
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             valid_in,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    output logic             ready_out,
    output logic             valid_out,
    output logic [WIDTH-1:0] q,
    output logic [WIDTH-1:0] r,
    output logic             div_by_zero
);

    localparam int CNT_W = div_cnt_width(WIDTH);

    div_state_t       r_state;
    div_state_t       w_state_next;
    logic [WIDTH-1:0] r_dividend;
    logic [WIDTH-1:0] r_divisor;
    // A restored remainder is always below the divisor, so its extra MSB
    // would be constant zero; the step widens it transiently instead.
    logic [WIDTH-1:0] r_rem;
    logic [CNT_W-1:0] r_cnt;
    logic             r_dbz_pend;
    logic [WIDTH-1:0] r_q;
    logic [WIDTH-1:0] r_r;
    logic             r_dbz;
    logic [WIDTH-1:0] w_rem_next;
    logic             w_q_bit;
    logic             w_last;

    div_step #(
        .WIDTH          (WIDTH)
    ) u_div_step (
        .i_rem          (r_rem),
        .i_dividend_msb (r_dividend[WIDTH-1]),
        .i_divisor      (r_divisor),
        .o_rem          (w_rem_next),
        .o_q_bit        (w_q_bit)
    );

    assign w_last = (r_cnt == CNT_W'(1));

    always_ff @(posedge clk) begin
        if (reset) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_state_next;
        end
    end

    always_comb begin
        w_state_next = r_state;
        ready_out    = 1'b0;
        valid_out    = 1'b0;
        case (r_state)
            IDLE: begin
                ready_out = 1'b1;
                if (valid_in) begin
                    w_state_next = RUN;
                end
            end
            RUN: begin
                if (w_last) begin
                    w_state_next = DONE;
                end
            end
            DONE: begin
                valid_out    = 1'b1;
                w_state_next = IDLE;
            end
            default: w_state_next = IDLE;
        endcase
    end

    // The dividend register doubles as the quotient shift register.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_dividend <= '0;
            r_divisor  <= '0;
            r_rem      <= '0;
            r_cnt      <= '0;
            r_dbz_pend <= 1'b0;
            r_q        <= '0;
            r_r        <= '0;
            r_dbz      <= 1'b0;
        end else begin
            case (r_state)
                IDLE: begin
                    if (valid_in) begin
                        r_dividend <= a;
                        r_divisor  <= b;
                        r_rem      <= '0;
                        r_cnt      <= CNT_W'(WIDTH);
                        r_dbz_pend <= (b == '0);
                    end
                end
                RUN: begin
                    r_rem      <= w_rem_next;
                    r_dividend <= {r_dividend[WIDTH-2:0], w_q_bit};
                    r_cnt      <= r_cnt - CNT_W'(1);
                    if (w_last) begin
                        r_q   <= {r_dividend[WIDTH-2:0], w_q_bit};
                        r_r   <= w_rem_next;
                        r_dbz <= r_dbz_pend;
                    end
                end
                default: begin
                end
            endcase
        end
    end

    assign q           = r_q;
    assign r           = r_r;
    assign div_by_zero = r_dbz;

endmodule
`default_nettype wire

// File: tb/tb_divider_iterative.sv
`default_nettype none
// ============================================================================
// Module      : tb_divider_iterative
// Description : Scoreboard bench for divider_iterative with directed vectors.
// Revision    : 1.0  initial release
// ============================================================================
module tb_divider_iterative;

    localparam int WIDTH     = 32;
    // Sampled 1 time unit after edges; DONE is visible after edge E+WIDTH.
    localparam int LAT_EDGES = WIDTH;

    typedef struct {
        logic [WIDTH-1:0] q;
        logic [WIDTH-1:0] r;
        logic             dbz;
        int               acc;
    } exp_t;

    logic             clk = 1'b0;
    logic             reset = 1'b1;
    logic             valid_in = 1'b0;
    logic [WIDTH-1:0] a = '0;
    logic [WIDTH-1:0] b = '0;
    logic             ready_out;
    logic             valid_out;
    logic [WIDTH-1:0] q;
    logic [WIDTH-1:0] r;
    logic             div_by_zero;

    exp_t sb[$];
    int   cyc   = 0;
    int   n_vec = 0;
    int   n_cmp = 0;
    int   n_err = 0;

    divider_iterative #(.WIDTH(WIDTH)) dut (
        .clk         (clk),
        .reset       (reset),
        .valid_in    (valid_in),
        .a           (a),
        .b           (b),
        .ready_out   (ready_out),
        .valid_out   (valid_out),
        .q           (q),
        .r           (r),
        .div_by_zero (div_by_zero)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string name, input logic [WIDTH-1:0] act,
                         input logic [WIDTH-1:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%08h, want 0x%08h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    // Monitor: pops the scoreboard whenever the DUT presents a result.
    always @(posedge clk) begin
        exp_t e;
        #1;
        if (valid_out) begin
            if (sb.size() == 0) begin
                n_cmp++;
                n_err++;
                $display("FAIL unexpected_valid: got valid_out=1 with q=0x%08h, want no result", q);
            end else begin
                e = sb.pop_front();
                check("q", q, e.q);
                check("r", r, e.r);
                check("div_by_zero", {31'b0, div_by_zero}, {31'b0, e.dbz});
                check("latency", WIDTH'(cyc - e.acc), WIDTH'(LAT_EDGES));
            end
        end
        if (valid_out && ready_out) begin
            n_cmp++;
            n_err++;
            $display("FAIL valid_ready_overlap: got both high, want never together");
        end
    end

    // Called 1 time unit after an edge; returns 1 time unit after the accept edge.
    task automatic issue(input logic [WIDTH-1:0] ta, input logic [WIDTH-1:0] tb_v,
                         input logic [WIDTH-1:0] eq, input logic [WIDTH-1:0] er,
                         input logic edbz);
        int k;
        valid_in = 1'b1;
        a        = ta;
        b        = tb_v;
        k        = 0;
        while (!ready_out && k < 200) begin
            @(posedge clk);
            #1;
            k++;
        end
        if (!ready_out) begin
            n_err++;
            $display("FAIL ready_timeout: got ready_out=0 for 200 cycles, want 1");
        end
        @(posedge clk);
        #1;
        sb.push_back('{q: eq, r: er, dbz: edbz, acc: cyc});
        n_vec++;
        valid_in = 1'b0;
    endtask

    task automatic drain();
        int k;
        k = 0;
        while (sb.size() != 0 && k < 100) begin
            @(posedge clk);
            #1;
            k++;
        end
        if (sb.size() != 0) begin
            n_err++;
            $display("FAIL drain_timeout: got %0d pending results, want 0", sb.size());
            sb.delete();
        end
        @(posedge clk);
        #1;
    endtask

    initial begin
        repeat (2) @(posedge clk);
        #1;
        reset = 1'b0;
        check("rst_ready", {31'b0, ready_out}, 32'd1);
        check("rst_valid", {31'b0, valid_out}, 32'd0);
        check("rst_q", q, 32'd0);
        check("rst_r", r, 32'd0);
        check("rst_dbz", {31'b0, div_by_zero}, 32'd0);

        // 100/7 with ready_out watched through the whole operation.
        issue(32'd100, 32'd7, 32'd14, 32'd2, 1'b0);
        for (int i = 0; i <= WIDTH; i++) begin
            check("busy_ready", {31'b0, ready_out}, 32'd0);
            @(posedge clk);
            #1;
        end
        check("ready_after_done", {31'b0, ready_out}, 32'd1);

        issue(32'hFFFF_FFFF, 32'd1, 32'hFFFF_FFFF, 32'd0, 1'b0);
        issue(32'd5, 32'd9, 32'd0, 32'd5, 1'b0);
        issue(32'h1234_5678, 32'd0, 32'hFFFF_FFFF, 32'h1234_5678, 1'b1);

        // Second request is driven (valid_in held) during RUN of the first.
        issue(32'd100, 32'd7, 32'd14, 32'd2, 1'b0);
        issue(32'd50, 32'd5, 32'd10, 32'd0, 1'b0);

        issue(32'd0, 32'd5, 32'd0, 32'd0, 1'b0);
        issue(32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'd1, 32'd0, 1'b0);
        issue(32'd7, 32'hFFFF_FFFF, 32'd0, 32'd7, 1'b0);
        issue(32'hFFFF_FFFF, 32'd2, 32'h7FFF_FFFF, 32'd1, 1'b0);
        issue(32'd1000, 32'd3, 32'd333, 32'd1, 1'b0);
        issue(32'h8000_0000, 32'h10, 32'h0800_0000, 32'd0, 1'b0);
        issue(32'd0, 32'd0, 32'hFFFF_FFFF, 32'd0, 1'b1);
        issue(32'd1, 32'd1, 32'd1, 32'd0, 1'b0);
        drain();

        // Results persist while idle.
        repeat (5) @(posedge clk);
        #1;
        check("hold_q", q, 32'd1);
        check("hold_r", r, 32'd0);

        // Abort 1000/3 with reset at RUN cycle 10; no result may appear.
        valid_in = 1'b1;
        a        = 32'd1000;
        b        = 32'd3;
        @(posedge clk);
        #1;
        valid_in = 1'b0;
        n_vec++;
        repeat (9) @(posedge clk);
        #1;
        reset = 1'b1;
        @(posedge clk);
        #1;
        reset = 1'b0;
        check("abort_ready", {31'b0, ready_out}, 32'd1);
        check("abort_q", q, 32'd0);
        check("abort_r", r, 32'd0);
        check("abort_dbz", {31'b0, div_by_zero}, 32'd0);
        repeat (40) @(posedge clk);
        #1;

        issue(32'd1000, 32'd3, 32'd333, 32'd1, 1'b0);
        drain();

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
`default_nettype wire
